// File: rtl/i2c_slave_regif.sv
// I2C target that maps bus transfers onto a local register bank: device address, register address,
// then auto-incrementing write or read bytes. SCL/SDA are synchronised and glitch-filtered first.

module i2c_slave_regif_filt #(
   parameter int unsigned p_FILTER = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic lvl
);
   logic [1:0] sync;
   logic [3:0] cnt;

   // Presets to 1 so an idle bus is assumed out of reset and no event fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= 2'b11;
         cnt  <= '0;
         lvl  <= 1'b1;
      end else begin
         sync <= {sync[0], pad};
         if (sync[1] == lvl) begin
            cnt <= '0;
         end else if (cnt == 4'(p_FILTER - 1)) begin
            lvl <= sync[1];
            cnt <= '0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end
endmodule

module i2c_slave_regif #(
   parameter logic [6:0]  p_DEV_ADDR = 7'h50,
   parameter int unsigned p_FILTER   = 3
) (
   input  logic       i_local_clk,
   input  logic       i_rst,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_wr_data,
   output logic       o_wr_en,
   output logic       o_rd_req,
   input  logic [7:0] i_rd_data,
   output logic       o_busy
);
   typedef enum logic [3:0] {
      S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR, S_REG_ACK,
      S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
   } state_t;

   logic [1:0] pads, filt;
   assign pads = {i_scl, i_sda};

   for (genvar g = 0; g < 2; g++) begin : g_filt
      i2c_slave_regif_filt #(.p_FILTER(p_FILTER)) u_filt (
         .clk (i_local_clk),
         .rst (i_rst),
         .pad (pads[g]),
         .lvl (filt[g])
      );
   end

   logic scl_f, sda_f, scl_d, sda_d;
   logic scl_rise, scl_fall, start_ev, stop_ev;
   assign scl_f    = filt[1];
   assign sda_f    = filt[0];
   assign scl_rise = scl_f & ~scl_d;
   assign scl_fall = ~scl_f & scl_d;
   assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
   assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;

   state_t     state, state_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] shreg, shreg_nxt, tx, tx_nxt, addr_nxt, wdata_nxt, byte_in;
   logic       rw, rw_nxt, rd_load, sda_nxt, wr_en_nxt, rd_req_nxt;

   assign byte_in = {shreg[6:0], sda_f};
   assign o_busy  = (state != S_IDLE);

   always_ff @(posedge i_local_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         tx         <= '0;
         rw         <= 1'b0;
         rd_load    <= 1'b0;
         scl_d      <= 1'b1;
         sda_d      <= 1'b1;
         o_sda      <= 1'b1;
         o_reg_addr <= '0;
         o_wr_data  <= '0;
         o_wr_en    <= 1'b0;
         o_rd_req   <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shreg      <= shreg_nxt;
         tx         <= tx_nxt;
         rw         <= rw_nxt;
         rd_load    <= o_rd_req;
         scl_d      <= scl_f;
         sda_d      <= sda_f;
         o_sda      <= sda_nxt;
         o_reg_addr <= addr_nxt;
         o_wr_data  <= wdata_nxt;
         o_wr_en    <= wr_en_nxt;
         o_rd_req   <= rd_req_nxt;
      end
   end

   // ACK states use bit_cnt as a phase flag: 0 = waiting for the fall that starts the ACK
   // (or, in S_RD_ACK, for the master's ACK bit), 1 = ACK in progress.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      tx_nxt      = rd_load ? i_rd_data : tx;
      rw_nxt      = rw;
      sda_nxt     = o_sda;
      addr_nxt    = o_reg_addr;
      wdata_nxt   = o_wr_data;
      wr_en_nxt   = 1'b0;
      rd_req_nxt  = 1'b0;
      if (start_ev) begin
         state_nxt   = S_DEV_ADDR;
         bit_cnt_nxt = '0;
         sda_nxt     = 1'b1;
      end else if (stop_ev) begin
         state_nxt   = S_IDLE;
         bit_cnt_nxt = '0;
         sda_nxt     = 1'b1;
      end else begin
         case (state)
            S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
               if (scl_rise) begin
                  shreg_nxt   = byte_in;
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     case (state)
                        S_DEV_ADDR: begin
                           if (byte_in[7:1] == p_DEV_ADDR) begin
                              rw_nxt    = byte_in[0];
                              state_nxt = S_DEV_ACK;
                           end else begin
                              state_nxt = S_IDLE;
                           end
                        end
                        S_REG_ADDR: begin
                           addr_nxt  = byte_in;
                           state_nxt = S_REG_ACK;
                        end
                        default: begin
                           wdata_nxt = byte_in;
                           wr_en_nxt = 1'b1;
                           state_nxt = S_WR_ACK;
                        end
                     endcase
                  end
               end
            end
            S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
               if (scl_fall) begin
                  if (bit_cnt == 3'd0) begin
                     sda_nxt     = 1'b0;
                     bit_cnt_nxt = 3'd1;
                  end else begin
                     sda_nxt     = 1'b1;
                     bit_cnt_nxt = '0;
                     case (state)
                        S_DEV_ACK: begin
                           if (rw) begin
                              state_nxt = S_RD_DATA;
                              sda_nxt   = tx[7];
                              tx_nxt    = {tx[6:0], 1'b0};
                           end else begin
                              state_nxt = S_REG_ADDR;
                           end
                        end
                        S_REG_ACK: state_nxt = S_WR_DATA;
                        default: begin
                           addr_nxt  = o_reg_addr + 8'd1;
                           state_nxt = S_WR_DATA;
                        end
                     endcase
                  end
               end else if (scl_rise && state == S_DEV_ACK && rw && bit_cnt == 3'd1) begin
                  rd_req_nxt = 1'b1;
               end
            end
            S_RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_nxt     = 1'b1;
                     bit_cnt_nxt = '0;
                     state_nxt   = S_RD_ACK;
                  end else begin
                     sda_nxt     = tx[7];
                     tx_nxt      = {tx[6:0], 1'b0};
                     bit_cnt_nxt = bit_cnt + 3'd1;
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise && bit_cnt == 3'd0) begin
                  if (!sda_f) begin
                     addr_nxt    = o_reg_addr + 8'd1;
                     rd_req_nxt  = 1'b1;
                     bit_cnt_nxt = 3'd1;
                  end else begin
                     state_nxt = S_IDLE;
                     sda_nxt   = 1'b1;
                  end
               end else if (scl_fall && bit_cnt == 3'd1) begin
                  state_nxt   = S_RD_DATA;
                  bit_cnt_nxt = '0;
                  sda_nxt     = tx[7];
                  tx_nxt      = {tx[6:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end
endmodule
